seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 8'hD0: base of the 3-register bus window.
REQ-002 Parameter REFRESH_DIV, default 50000: cycles each digit is shown (SHOW phase), legal range >= 2.
REQ-003 Parameter BLANK_CYCLES, default 16: anti-ghost dead cycles before each digit (BLANK phase), legal range >= 1.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RESETN  input  1  reset, asynchronous, active-low.
REQ-006 BUS_ADDR  input  8  processor bus address.
REQ-007 BUS_DATA_IN  input  8  processor write data.
REQ-008 BUS_WE  input  1  write strobe, one-cycle qualified write.
REQ-009 SEG_SELECT  output  2  digit index to the 7-seg decoder (0 = rightmost, 3 = leftmost).
REQ-010 BIN_OUT  output  4  nibble to the decoder; 4'h0 decodes to blank.
REQ-011 DOT_OUT  output  1  decimal point for the current digit, active-high.
REQ-012 FRAME_TICK  output  1  one-cycle pulse at each frame commit.

Function
REQ-013 Register map: BASE_ADDR+0 = digits 1:0 (bits 3:0 digit 0, bits 7:4 digit 1); BASE_ADDR+1 = digits 3:2 (bits 3:0 digit 2); BASE_ADDR+2 = dot mask, bit n = digit n, bits 7:4 ignored.
REQ-014 A write (BUS_WE=1, address match) updates the shadow register on that edge; non-matching addresses have no effect.
REQ-015 Display uses only active registers; shadow->active copy (all three at once) occurs only at a commit edge.
REQ-016 FSM states: BLANK, SHOW; one down/up phase counter and a 2-bit digit index.
REQ-017 BLANK: lasts exactly BLANK_CYCLES cycles; BIN_OUT=4'h0, DOT_OUT=0, SEG_SELECT=digit index; then -> SHOW, same digit, counter cleared.
REQ-018 SHOW: lasts exactly REFRESH_DIV cycles; BIN_OUT=active nibble of digit index, DOT_OUT=active dot bit; then -> BLANK, counter cleared.
REQ-019 SHOW->BLANK with digit index 3: index wraps to 0, commit occurs, FRAME_TICK=1 for that one cycle; otherwise index increments by 1.
REQ-020 Frame period = 4*(BLANK_CYCLES+REFRESH_DIV) cycles exactly, no gaps.
REQ-021 Write and commit on the same edge: active takes the pre-write shadow value; the written value is committed at the next frame.
REQ-022 All outputs registered; outputs reflect state of the current cycle with no combinational path from bus inputs.
REQ-023 Digit index never skips or repeats within a frame; sequence is 0,1,2,3,0,...

Reset
REQ-024 RESETN low asynchronously forces: state BLANK, digit index 0, counter 0, shadow and active registers 0, SEG_SELECT=0, BIN_OUT=0, DOT_OUT=0, FRAME_TICK=0.
REQ-025 Reset asserted mid-frame discards pending shadow writes; after release, BLANK of digit 0 starts on the first rising edge and first FRAME_TICK follows after exactly one full frame.
REQ-026 Bus writes during reset are ignored.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2; frame = 24 cycles)
REQ-027 Reset release, no writes -> SEG_SELECT cycles 0,0,0,0,0,0,1,...; BIN_OUT=0 throughout; FRAME_TICK pulses every 24 cycles, first on cycle 24 after release.
REQ-028 Write 8'h21 to 8'hD0, 8'h43 to 8'hD1, 8'h05 to 8'hD2 -> no change until next FRAME_TICK; following frame SHOW phases give BIN_OUT 1,2,3,4 with DOT_OUT 1,0,1,0; BLANK phases give BIN_OUT=0, DOT_OUT=0.
REQ-029 Write 8'h77 to 8'hD0 on the exact FRAME_TICK cycle -> that frame shows the old value; 7,7 appears on digits 0,1 only from the frame after.
REQ-030 Write to 8'hD3 and 8'hCF -> no register or display change.
REQ-031 Assert RESETN low during SHOW of digit 2 with pending shadow write -> all outputs 0 immediately (without clock edge); after release display stays blank and pending value never appears.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-segment display.
// A processor writes digit nibbles and a dot mask into shadow registers over a
// small bus window. Once per frame the shadow registers are copied into the active
// registers, so each frame shows one consistent value. Each digit is first blanked
// (anti-ghost) and then shown; the digit order is 0,1,2,3,0,...
//
// Ports:
//   CLK          system clock, rising edge
//   RESETN       asynchronous active-low reset
//   BUS_ADDR     processor bus address
//   BUS_DATA_IN  processor write data
//   BUS_WE       one-cycle qualified write strobe
//   SEG_SELECT   digit index to the decoder (0 = rightmost)
//   BIN_OUT      nibble to the decoder (4'h0 decodes to blank)
//   DOT_OUT      decimal point for the current digit
//   FRAME_TICK   one-cycle pulse in the cycle that ends with the frame commit
module seg7_scan_ctrl #(
  parameter logic [7:0]  BASE_ADDR    = 8'hD0,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [1:0] SEG_SELECT,
  output logic [3:0] BIN_OUT,
  output logic       DOT_OUT,
  output logic       FRAME_TICK
);

  // Phase counter must hold the longer of the two phase lengths minus one.
  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [7:0] ADDR_DIG_LO = BASE_ADDR;
  localparam logic [7:0] ADDR_DIG_HI = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_DOT    = BASE_ADDR + 8'd2;

  localparam logic [1:0] LAST_DIGIT = 2'd3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             commit;

  logic [7:0] shadow_lo, shadow_hi;
  logic [3:0] shadow_dot;
  logic [7:0] active_lo, active_hi;
  logic [3:0] active_dot;

  logic [1:0] seg_c;
  logic [3:0] bin_c;
  logic       dot_c;
  logic       tick_c;

  // Shadow registers: bus writes land here; reset discards anything pending.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      shadow_lo  <= 8'h00;
      shadow_hi  <= 8'h00;
      shadow_dot <= 4'h0;
    end else if (BUS_WE) begin
      if (BUS_ADDR == ADDR_DIG_LO) shadow_lo  <= BUS_DATA_IN;
      if (BUS_ADDR == ADDR_DIG_HI) shadow_hi  <= BUS_DATA_IN;
      if (BUS_ADDR == ADDR_DOT)    shadow_dot <= BUS_DATA_IN[3:0];
    end
  end

  // Active registers: copied as a set on the commit edge. A write on the same
  // edge is not seen here (non-blocking read of the old shadow value).
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      active_lo  <= 8'h00;
      active_hi  <= 8'h00;
      active_dot <= 4'h0;
    end else if (commit) begin
      active_lo  <= shadow_lo;
      active_hi  <= shadow_hi;
      active_dot <= shadow_dot;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic: BLANK then SHOW per digit, commit after the last digit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    idx_nxt   = idx;
    commit    = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          commit    = (idx == LAST_DIGIT);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Output logic, evaluated on the next state so the registered outputs
  // line up with the state they describe. Active registers never change on
  // a BLANK->SHOW edge, so their current value is the one that will be shown.
  always_comb begin
    seg_c  = idx_nxt;
    bin_c  = 4'h0;
    dot_c  = 1'b0;
    tick_c = 1'b0;
    if (state_nxt == ST_SHOW) begin
      unique case (idx_nxt)
        2'd0:    bin_c = active_lo[3:0];
        2'd1:    bin_c = active_lo[7:4];
        2'd2:    bin_c = active_hi[3:0];
        default: bin_c = active_hi[7:4];
      endcase
      dot_c  = active_dot[idx_nxt];
      tick_c = (idx_nxt == LAST_DIGIT) && (cnt_nxt == SHOW_LAST);
    end
  end

  // Output register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      SEG_SELECT <= 2'd0;
      BIN_OUT    <= 4'h0;
      DOT_OUT    <= 1'b0;
      FRAME_TICK <= 1'b0;
    end else begin
      SEG_SELECT <= seg_c;
      BIN_OUT    <= bin_c;
      DOT_OUT    <= dot_c;
      FRAME_TICK <= tick_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with a short frame
// (REFRESH_DIV=4, BLANK_CYCLES=2, 24-cycle frame). A frame-position model
// predicts the outputs from the number of clock edges since reset release.
module tb_seg7_scan_ctrl;

  localparam logic [7:0] BASE  = 8'hD0;
  localparam int         RD    = 4;
  localparam int         BC    = 2;
  localparam int         SLOT  = RD + BC;
  localparam int         FRAME = 4 * SLOT;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_DATA_IN = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [1:0] SEG_SELECT;
  logic [3:0] BIN_OUT;
  logic       DOT_OUT;
  logic       FRAME_TICK;

  always #5 CLK = ~CLK;

  seg7_scan_ctrl #(
    .BASE_ADDR   (BASE),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_WE     (BUS_WE),
    .SEG_SELECT (SEG_SELECT),
    .BIN_OUT    (BIN_OUT),
    .DOT_OUT    (DOT_OUT),
    .FRAME_TICK (FRAME_TICK)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  int         edges = 0;
  logic [3:0] sh_dig [4] = '{default: 4'h0};
  logic [3:0] act_dig[4] = '{default: 4'h0};
  logic [3:0] sh_dot  = 4'h0;
  logic [3:0] act_dot = 4'h0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, edges, $time);
    end
  endtask

  task model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == BASE) begin
      sh_dig[0] = d[3:0];
      sh_dig[1] = d[7:4];
    end else if (a == BASE + 8'd1) begin
      sh_dig[2] = d[3:0];
      sh_dig[3] = d[7:4];
    end else if (a == BASE + 8'd2) begin
      sh_dot = d[3:0];
    end
  endtask

  // Model: commit on every FRAME-th edge (using pre-write shadow), then apply write.
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      edges = 0;
      for (int i = 0; i < 4; i++) begin
        sh_dig[i]  = 4'h0;
        act_dig[i] = 4'h0;
      end
      sh_dot  = 4'h0;
      act_dot = 4'h0;
    end else begin
      edges++;
      if (edges % FRAME == 0) begin
        for (int i = 0; i < 4; i++) act_dig[i] = sh_dig[i];
        act_dot = sh_dot;
      end
      if (BUS_WE) model_write(BUS_ADDR, BUS_DATA_IN);
    end
  end

  // Compare outputs against frame position on every falling edge.
  always @(negedge CLK) begin : cmp
    int pos, d, w;
    bit show;
    if (chk_en) begin
      pos  = edges % FRAME;
      d    = pos / SLOT;
      w    = pos % SLOT;
      show = (w >= BC);
      check("seg_select", int'(SEG_SELECT), d);
      check("bin_out", int'(BIN_OUT), show ? int'(act_dig[d]) : 0);
      check("dot_out", int'(DOT_OUT), show ? int'(act_dot[d]) : 0);
      check("frame_tick", int'(FRAME_TICK), (pos == FRAME - 1) ? 1 : 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a falling edge; write is sampled on the following rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR    = a;
    BUS_DATA_IN = d;
    BUS_WE      = 1'b1;
    @(negedge CLK);
    BUS_WE      = 1'b0;
  endtask

  // Returns at the falling edge where the frame position equals p.
  task automatic wait_pos(input int p);
    int k;
    k = 0;
    @(negedge CLK);
    while ((edges % FRAME) != p && k < 4 * FRAME) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 4 * FRAME) check("wait_pos_timeout", edges % FRAME, p);
  endtask

  initial begin
    logic [7:0] a;
    chk_en = 1'b1;

    // Writes while in reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      BUS_ADDR = BASE + 8'($urandom_range(0, 2));
      BUS_DATA_IN = 8'($urandom);
      BUS_WE = 1'b1;
    end
    @(negedge CLK);
    BUS_WE = 1'b0;
    RESETN = 1'b1;
    idle(2 * FRAME);

    // Digits 1,2,3,4 with dots on digits 0 and 2.
    idle(5);
    bus_write(BASE, 8'h21);
    idle(3);
    bus_write(BASE + 8'd1, 8'h43);
    bus_write(BASE + 8'd2, 8'h05);
    idle(2 * FRAME);

    // Write on the FRAME_TICK cycle: committed only at the following frame.
    wait_pos(FRAME - 1);
    check("tick_at_write", int'(FRAME_TICK), 1);
    bus_write(BASE, 8'h77);
    idle(2 * FRAME + 3);

    // Out-of-window addresses.
    bus_write(BASE + 8'd3, 8'($urandom));
    bus_write(BASE - 8'd1, 8'($urandom));
    idle(2 * FRAME);

    // Random bus traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0:       a = BASE;
          1:       a = BASE + 8'd1;
          2:       a = BASE + 8'd2;
          3:       a = BASE + 8'd3;
          default: a = 8'($urandom);
        endcase
        BUS_ADDR    = a;
        BUS_DATA_IN = 8'($urandom);
        BUS_WE      = 1'b1;
      end else begin
        BUS_WE = 1'b0;
      end
      @(negedge CLK);
    end
    BUS_WE = 1'b0;

    // Known display, then reset during SHOW of digit 2 with a write pending.
    bus_write(BASE, 8'h21);
    bus_write(BASE + 8'd1, 8'h43);
    bus_write(BASE + 8'd2, 8'h0F);
    idle(2 * FRAME);
    wait_pos(2 * SLOT + BC + 1);
    BUS_ADDR    = BASE;
    BUS_DATA_IN = 8'h99;
    BUS_WE      = 1'b1;
    @(posedge CLK);
    #1 BUS_WE = 1'b0;
    check("pre_reset_bin", int'(BIN_OUT), 3);
    #1 RESETN = 1'b0;
    #1;
    check("async_seg", int'(SEG_SELECT), 0);
    check("async_bin", int'(BIN_OUT), 0);
    check("async_dot", int'(DOT_OUT), 0);
    check("async_tick", int'(FRAME_TICK), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      BUS_ADDR = BASE + 8'($urandom_range(0, 2));
      BUS_DATA_IN = 8'($urandom) | 8'h11;
      BUS_WE = 1'b1;
    end
    @(negedge CLK);
    BUS_WE = 1'b0;
    RESETN = 1'b1;
    idle(3 * FRAME);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
